// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: rename/complete/commit signal bundle for the reorder buffer
interface reorder_buffer_if;
    logic         Alloc_valid_IN;
    logic         Alloc_has_dest_IN;
    logic [5:0]   Alloc_phys_IN;
    logic [4:0]   Alloc_arch_IN;
    logic [31:0]  Alloc_addr_IN;
    logic [3:0]   Alloc_tag_OUT;
    logic         ROB_full;
    logic         ROB_empty;
    logic         Complete_valid_IN;
    logic [3:0]   Complete_tag_IN;
    logic         Complete_mispredict_IN;
    logic [31:0]  Complete_target_IN;
    logic         Commit_valid;
    logic [4:0]   Commit_arch;
    logic [5:0]   Commit_phys;
    logic         Freed_valid;
    logic [5:0]   Freed_phys;
    logic         Flush;
    logic [31:0]  Flush_PC;
    logic [191:0] RRAT_OUT;

    modport slave (
        input  Alloc_valid_IN, Alloc_has_dest_IN, Alloc_phys_IN, Alloc_arch_IN, Alloc_addr_IN,
        input  Complete_valid_IN, Complete_tag_IN, Complete_mispredict_IN, Complete_target_IN,
        output Alloc_tag_OUT, ROB_full, ROB_empty, Commit_valid, Commit_arch, Commit_phys,
        output Freed_valid, Freed_phys, Flush, Flush_PC, RRAT_OUT
    );

    modport master (
        output Alloc_valid_IN, Alloc_has_dest_IN, Alloc_phys_IN, Alloc_arch_IN, Alloc_addr_IN,
        output Complete_valid_IN, Complete_tag_IN, Complete_mispredict_IN, Complete_target_IN,
        input  Alloc_tag_OUT, ROB_full, ROB_empty, Commit_valid, Commit_arch, Commit_phys,
        input  Freed_valid, Freed_phys, Flush, Flush_PC, RRAT_OUT
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement of out-of-order completions, with retirement RAT
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int LOG_ROB   = 4,
    parameter int LOG_PHYS  = 6,
    parameter int NUM_ARCH  = 32,
    parameter int LOG_ARCH  = 5
) (
    input logic              CLK,
    input logic              RESET,
    reorder_buffer_if.slave  rob
);
    logic [LOG_ROB-1:0]   head_q, head_d, tail_q, tail_d, comp_off;
    logic [LOG_ROB:0]     count_q, count_d;
    logic [ROB_DEPTH-1:0] done_q, done_d, mispredict_q, mispredict_d, has_dest_q, has_dest_d;
    logic [LOG_ARCH-1:0]  arch_q [ROB_DEPTH];
    logic [LOG_ARCH-1:0]  arch_d [ROB_DEPTH];
    logic [LOG_PHYS-1:0]  phys_q [ROB_DEPTH];
    logic [LOG_PHYS-1:0]  phys_d [ROB_DEPTH];
    logic [31:0]          target_q [ROB_DEPTH];
    logic [31:0]          target_d [ROB_DEPTH];
    logic [LOG_PHYS-1:0]  rrat_q [NUM_ARCH];
    logic [LOG_PHYS-1:0]  rrat_d [NUM_ARCH];
    logic                 commit_valid_q, commit_valid_d, freed_valid_q, freed_valid_d, flush_q, flush_d;
    logic [LOG_ARCH-1:0]  commit_arch_q, commit_arch_d;
    logic [LOG_PHYS-1:0]  commit_phys_q, commit_phys_d, freed_phys_q, freed_phys_d;
    logic [31:0]          flush_pc_q, flush_pc_d;
    logic [NUM_ARCH*LOG_PHYS-1:0] rrat_out;
    logic                 full, retire, flush, alloc, comp, head_dest;

    assign full = count_q == (LOG_ROB+1)'(ROB_DEPTH);

    always_comb begin
        retire    = count_q != '0 && done_q[head_q];
        flush     = retire && mispredict_q[head_q];
        head_dest = has_dest_q[head_q];
        alloc     = rob.Alloc_valid_IN && !full && !flush;
        // occupied tags lie within [head, head+count) modulo the ring size
        comp_off  = rob.Complete_tag_IN - head_q;
        comp      = rob.Complete_valid_IN && ({1'b0, comp_off} < count_q) && !flush;
        head_d    = flush ? '0 : head_q + LOG_ROB'(retire);
        tail_d    = flush ? '0 : tail_q + LOG_ROB'(alloc);
        count_d   = flush ? '0 : count_q + (LOG_ROB+1)'(alloc) - (LOG_ROB+1)'(retire);
        done_d       = done_q;
        mispredict_d = mispredict_q;
        has_dest_d   = has_dest_q;
        arch_d       = arch_q;
        phys_d       = phys_q;
        target_d     = target_q;
        rrat_d       = rrat_q;
        if (comp) begin
            done_d[rob.Complete_tag_IN]       = 1'b1;
            mispredict_d[rob.Complete_tag_IN] = rob.Complete_mispredict_IN;
            target_d[rob.Complete_tag_IN]     = rob.Complete_target_IN;
        end
        if (alloc) begin
            done_d[tail_q]       = 1'b0;
            mispredict_d[tail_q] = 1'b0;
            has_dest_d[tail_q]   = rob.Alloc_has_dest_IN && rob.Alloc_arch_IN != '0;
            arch_d[tail_q]       = rob.Alloc_arch_IN;
            phys_d[tail_q]       = rob.Alloc_phys_IN;
        end
        if (flush)
            done_d = '0;
        if (retire && head_dest)
            rrat_d[arch_q[head_q]] = phys_q[head_q];
        commit_valid_d = retire;
        commit_arch_d  = retire ? arch_q[head_q] : commit_arch_q;
        commit_phys_d  = retire ? phys_q[head_q] : commit_phys_q;
        freed_valid_d  = retire && head_dest;
        freed_phys_d   = (retire && head_dest) ? rrat_q[arch_q[head_q]] : freed_phys_q;
        flush_d        = flush;
        flush_pc_d     = flush ? target_q[head_q] : flush_pc_q;
    end

    always_comb begin
        rrat_out = '0;
        for (int i = 0; i < NUM_ARCH; i++)
            rrat_out[i*LOG_PHYS +: LOG_PHYS] = rrat_q[i];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            done_q         <= '0;
            commit_valid_q <= 1'b0;
            commit_arch_q  <= '0;
            commit_phys_q  <= '0;
            freed_valid_q  <= 1'b0;
            freed_phys_q   <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
            for (int i = 0; i < NUM_ARCH; i++)
                rrat_q[i] <= LOG_PHYS'(i);
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            done_q         <= done_d;
            commit_valid_q <= commit_valid_d;
            commit_arch_q  <= commit_arch_d;
            commit_phys_q  <= commit_phys_d;
            freed_valid_q  <= freed_valid_d;
            freed_phys_q   <= freed_phys_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
            rrat_q         <= rrat_d;
        end
    end

    // payload is only meaningful while its done/occupancy state says so
    always_ff @(posedge CLK) begin
        mispredict_q <= mispredict_d;
        has_dest_q   <= has_dest_d;
        arch_q       <= arch_d;
        phys_q       <= phys_d;
        target_q     <= target_d;
    end

    assign rob.Alloc_tag_OUT = tail_q;
    assign rob.ROB_full      = full;
    assign rob.ROB_empty     = count_q == '0;
    assign rob.Commit_valid  = commit_valid_q;
    assign rob.Commit_arch   = commit_arch_q;
    assign rob.Commit_phys   = commit_phys_q;
    assign rob.Freed_valid   = freed_valid_q;
    assign rob.Freed_phys    = freed_phys_q;
    assign rob.Flush         = flush_q;
    assign rob.Flush_PC      = flush_pc_q;
    assign rob.RRAT_OUT      = rrat_out;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenario tests for reorder_buffer with hand-computed expectations
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    reorder_buffer_if rif();
    reorder_buffer dut (.CLK(clk), .RESET(rst), .rob(rif));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.Alloc_valid_IN         = 1'b0;
        rif.Alloc_has_dest_IN      = 1'b0;
        rif.Alloc_phys_IN          = '0;
        rif.Alloc_arch_IN          = '0;
        rif.Alloc_addr_IN          = '0;
        rif.Complete_valid_IN      = 1'b0;
        rif.Complete_tag_IN        = '0;
        rif.Complete_mispredict_IN = 1'b0;
        rif.Complete_target_IN     = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] arch, input logic [5:0] phys);
        rif.Alloc_valid_IN    = 1'b1;
        rif.Alloc_has_dest_IN = 1'b1;
        rif.Alloc_arch_IN     = arch;
        rif.Alloc_phys_IN     = phys;
        rif.Alloc_addr_IN     = 32'h0040_0000 + {25'd0, phys, 2'b00};
    endtask

    task automatic complete(input logic [3:0] tag, input logic mp, input logic [31:0] tgt);
        rif.Complete_valid_IN      = 1'b1;
        rif.Complete_tag_IN        = tag;
        rif.Complete_mispredict_IN = mp;
        rif.Complete_target_IN     = tgt;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rif.ROB_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", rif.ROB_empty); end
        checks++; if (rif.ROB_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", rif.ROB_full); end
        checks++; if (rif.Alloc_tag_OUT !== 4'd0) begin errors++; $display("FAIL reset_tag got %0d exp 0", rif.Alloc_tag_OUT); end
        checks++; if ({rif.Commit_valid, rif.Freed_valid, rif.Flush} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {rif.Commit_valid, rif.Freed_valid, rif.Flush}); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (rif.RRAT_OUT[6*i +: 6] !== 6'(i)) begin errors++; $display("FAIL reset_rrat[%0d] got %0d exp %0d", i, rif.RRAT_OUT[6*i +: 6], i); end
        end
    endtask

    task automatic test_basic_commit();
        do_reset();
        alloc(5'd3, 6'd40);
        step();
        idle();
        checks++; if (rif.Alloc_tag_OUT !== 4'd1 || rif.ROB_empty !== 1'b0) begin errors++; $display("FAIL basic_alloc tag %0d empty %0b exp 1/0", rif.Alloc_tag_OUT, rif.ROB_empty); end
        complete(4'd0, 1'b0, 32'h0);
        step();
        idle();
        checks++; if (rif.Commit_valid !== 1'b0) begin errors++; $display("FAIL basic_latency commit got %0b exp 0", rif.Commit_valid); end
        step();
        checks++; if (rif.Commit_valid !== 1'b1 || rif.Commit_arch !== 5'd3 || rif.Commit_phys !== 6'd40) begin errors++; $display("FAIL basic_commit v %0b arch %0d phys %0d exp 1/3/40", rif.Commit_valid, rif.Commit_arch, rif.Commit_phys); end
        checks++; if (rif.Freed_valid !== 1'b1 || rif.Freed_phys !== 6'd3) begin errors++; $display("FAIL basic_freed v %0b phys %0d exp 1/3", rif.Freed_valid, rif.Freed_phys); end
        checks++; if (rif.RRAT_OUT[18 +: 6] !== 6'd40 || rif.ROB_empty !== 1'b1) begin errors++; $display("FAIL basic_rrat arch3 %0d empty %0b exp 40/1", rif.RRAT_OUT[18 +: 6], rif.ROB_empty); end
        complete(4'd5, 1'b0, 32'h0);
        step();
        idle();
        checks++; if (rif.Commit_valid !== 1'b0 || rif.Freed_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse commit %0b freed %0b exp 0/0", rif.Commit_valid, rif.Freed_valid); end
        step();
        checks++; if (rif.Commit_valid !== 1'b0) begin errors++; $display("FAIL basic_unoccupied commit got %0b exp 0", rif.Commit_valid); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(5'(i + 1), 6'(32 + i));
            step();
        end
        idle();
        checks++; if (rif.ROB_full !== 1'b1 || rif.Alloc_tag_OUT !== 4'd0) begin errors++; $display("FAIL wrap_full full %0b tag %0d exp 1/0", rif.ROB_full, rif.Alloc_tag_OUT); end
        alloc(5'd20, 6'd63);
        step();
        idle();
        checks++; if (rif.ROB_full !== 1'b1 || rif.Alloc_tag_OUT !== 4'd0) begin errors++; $display("FAIL wrap_17th full %0b tag %0d exp 1/0", rif.ROB_full, rif.Alloc_tag_OUT); end
        for (int t = 15; t >= 0; t--) begin
            complete(4'(t), 1'b0, 32'h0);
            step();
            checks++; if (rif.Commit_valid !== 1'b0) begin errors++; $display("FAIL wrap_early_commit tag %0d got %0b exp 0", t, rif.Commit_valid); end
        end
        idle();
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (rif.Commit_valid !== 1'b1 || rif.Commit_phys !== 6'(32 + k) || rif.Commit_arch !== 5'(k + 1) || rif.Freed_phys !== 6'(k + 1)) begin
                errors++;
                $display("FAIL wrap_retire[%0d] v %0b phys %0d arch %0d freed %0d exp 1/%0d/%0d/%0d", k, rif.Commit_valid, rif.Commit_phys, rif.Commit_arch, rif.Freed_phys, 32 + k, k + 1, k + 1);
            end
        end
        checks++; if (rif.ROB_empty !== 1'b1 || rif.Alloc_tag_OUT !== 4'd0) begin errors++; $display("FAIL wrap_end empty %0b tag %0d exp 1/0", rif.ROB_empty, rif.Alloc_tag_OUT); end
        step();
        checks++; if (rif.Commit_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle commit got %0b exp 0", rif.Commit_valid); end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc(5'(i + 1), 6'(41 + i));
            step();
        end
        idle();
        complete(4'd1, 1'b1, 32'h0040_0100);
        step();
        complete(4'd0, 1'b0, 32'h0);
        step();
        idle();
        step();
        checks++; if (rif.Commit_valid !== 1'b1 || rif.Commit_phys !== 6'd41 || rif.Flush !== 1'b0) begin errors++; $display("FAIL mp_tag0 v %0b phys %0d flush %0b exp 1/41/0", rif.Commit_valid, rif.Commit_phys, rif.Flush); end
        alloc(5'd9, 6'd9);
        complete(4'd2, 1'b0, 32'h0);
        step();
        idle();
        checks++; if (rif.Commit_valid !== 1'b1 || rif.Commit_phys !== 6'd42 || rif.Flush !== 1'b1) begin errors++; $display("FAIL mp_tag1 v %0b phys %0d flush %0b exp 1/42/1", rif.Commit_valid, rif.Commit_phys, rif.Flush); end
        checks++; if (rif.Flush_PC !== 32'h0040_0100) begin errors++; $display("FAIL mp_flush_pc got %h exp 00400100", rif.Flush_PC); end
        checks++; if (rif.ROB_empty !== 1'b1 || rif.Alloc_tag_OUT !== 4'd0) begin errors++; $display("FAIL mp_cleared empty %0b tag %0d exp 1/0", rif.ROB_empty, rif.Alloc_tag_OUT); end
        complete(4'd2, 1'b0, 32'h0);
        step();
        idle();
        checks++; if (rif.Flush !== 1'b0 || rif.Commit_valid !== 1'b0) begin errors++; $display("FAIL mp_after flush %0b commit %0b exp 0/0", rif.Flush, rif.Commit_valid); end
        step();
        checks++; if (rif.Commit_valid !== 1'b0 || rif.ROB_empty !== 1'b1) begin errors++; $display("FAIL mp_tag2 commit %0b empty %0b exp 0/1", rif.Commit_valid, rif.ROB_empty); end
    endtask

    task automatic test_arch0();
        do_reset();
        alloc(5'd0, 6'd50);
        step();
        idle();
        complete(4'd0, 1'b0, 32'h0);
        step();
        idle();
        step();
        checks++; if (rif.Commit_valid !== 1'b1 || rif.Freed_valid !== 1'b0) begin errors++; $display("FAIL arch0 commit %0b freed %0b exp 1/0", rif.Commit_valid, rif.Freed_valid); end
        checks++; if (rif.RRAT_OUT[0 +: 6] !== 6'd0) begin errors++; $display("FAIL arch0_rrat got %0d exp 0", rif.RRAT_OUT[0 +: 6]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(5'(i + 1), 6'(i));
            step();
        end
        idle();
        complete(4'd0, 1'b0, 32'h0);
        step();
        alloc(5'd7, 6'd60);
        rif.Complete_valid_IN = 1'b0;
        step();
        checks++; if (rif.Commit_valid !== 1'b1 || rif.Commit_phys !== 6'd0) begin errors++; $display("FAIL b2b_retire v %0b phys %0d exp 1/0", rif.Commit_valid, rif.Commit_phys); end
        checks++; if (rif.ROB_full !== 1'b0 || rif.ROB_empty !== 1'b0 || rif.Alloc_tag_OUT !== 4'd0) begin errors++; $display("FAIL b2b_refused full %0b empty %0b tag %0d exp 0/0/0", rif.ROB_full, rif.ROB_empty, rif.Alloc_tag_OUT); end
        step();
        idle();
        checks++; if (rif.ROB_full !== 1'b1 || rif.Alloc_tag_OUT !== 4'd1 || rif.Commit_valid !== 1'b0) begin errors++; $display("FAIL b2b_refill full %0b tag %0d commit %0b exp 1/1/0", rif.ROB_full, rif.Alloc_tag_OUT, rif.Commit_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc(5'd4, 6'd44);
        step();
        idle();
        complete(4'd0, 1'b1, 32'h1234_5678);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (rif.Commit_valid !== 1'b0 || rif.Flush !== 1'b0 || rif.ROB_empty !== 1'b1) begin errors++; $display("FAIL mid_reset commit %0b flush %0b empty %0b exp 0/0/1", rif.Commit_valid, rif.Flush, rif.ROB_empty); end
        step();
        checks++; if (rif.Commit_valid !== 1'b0 || rif.RRAT_OUT[24 +: 6] !== 6'd4) begin errors++; $display("FAIL mid_after commit %0b arch4 %0d exp 0/4", rif.Commit_valid, rif.RRAT_OUT[24 +: 6]); end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_mispredict();
        test_arch0();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
